cell_rmw_seq: RTL and testbench

Read-modify-write sequencer that drives the ALU on behalf of the BeeF decode stage. It accepts a run-length inc/dec request, a data-memory address and a repeat count. It reads the addressed cell and steps it through the ALU once per cycle, `count` times, then writes the result back and pulses `done_o`. It sits between decode, data memory and the `alu` instance, and owns every data-cell update.

---
 rtl/definitions.sv | 18 +
 rtl/alu.sv | 21 ++
 rtl/cell_rmw_seq.sv | 170 +++++++++++++++++
 tb/tb_cell_rmw_seq.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/definitions.sv
// Shared type definitions for the BeeF datapath: ALU opcodes and the
// read-modify-write sequencer state encoding.
package definitions;

  typedef enum logic {
    ALU_INC = 1'b0,
    ALU_DEC = 1'b1
  } ALU_OP;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    LOAD  = 3'd2,
    APPLY = 3'd3,
    WRITE = 3'd4
  } RMW_STATE;

endpackage

// File: rtl/alu.sv
// Single-step cell ALU: increments or decrements its operand modulo 2^WIDTH.
module alu
  import definitions::*;
#(
  parameter int WIDTH = 8
) (
  input  ALU_OP            op_i,
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = a_i;
    unique case (op_i)
      ALU_INC: y_o = a_i + WIDTH'(1);
      ALU_DEC: y_o = a_i - WIDTH'(1);
      default: y_o = a_i;
    endcase
  end

endmodule

// File: rtl/cell_rmw_seq.sv
// Read-modify-write sequencer: reads a data cell, steps it through the ALU
// `count` times and writes it back. BEEF_CELL_CACHE_EN adds a one-entry tag.
module cell_rmw_seq
  import definitions::*;
#(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  ALU_OP             req_op_i,
  input  logic [CNT_W-1:0]  req_count_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [WIDTH-1:0]  mem_rd_data_i,
  output logic              mem_wr_en_o,
  output logic [WIDTH-1:0]  mem_wr_data_o,
  output logic              done_o,
  output logic              zero_o
);

  RMW_STATE          state_q, state_d;
  ALU_OP             op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic              noop_q, noop_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;
  logic [WIDTH-1:0]  wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              done_q, done_d;
  logic              zero_q, zero_d;

  logic [WIDTH-1:0]  alu_y;
  logic              tag_hit;
  logic [WIDTH-1:0]  tag_data;

  alu #(.WIDTH(WIDTH)) u_alu (
    .op_i(op_q),
    .a_i (acc_q),
    .y_o (alu_y)
  );

`ifdef BEEF_CELL_CACHE_EN
  logic              tag_valid_q;
  logic [ADDR_W-1:0] tag_addr_q;
  logic [WIDTH-1:0]  tag_data_q;
  logic              tag_wr;

  assign tag_wr   = (state_q == WRITE) && !noop_q;
  assign tag_hit  = tag_valid_q && (tag_addr_q == req_addr_i);
  assign tag_data = tag_data_q;

  always_ff @(posedge clk) begin
    if (reset)       tag_valid_q <= 1'b0;
    else if (tag_wr) tag_valid_q <= 1'b1;
  end

  // NOTE: only the valid bit needs reset; addr/data are never consumed while
  // invalid, so leaving them unreset keeps them plain storage.
  always_ff @(posedge clk) begin
    if (tag_wr) begin
      tag_addr_q <= addr_q;
      tag_data_q <= acc_q;
    end
  end
`else
  assign tag_hit  = 1'b0;
  assign tag_data = '0;
`endif

  // NOTE: every variable gets its hold value first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    acc_d   = acc_q;
    noop_d  = noop_q;
    zero_d  = zero_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          op_d   = req_op_i;
          cnt_d  = req_count_i;
          addr_d = req_addr_i;
          noop_d = (req_count_i == '0);
          if (req_count_i == '0) begin
            state_d = WRITE;
          end else if (tag_hit) begin
            acc_d   = tag_data;
            state_d = APPLY;
          end else begin
            state_d = READ;
          end
        end
      end
      READ:  state_d = LOAD;
      LOAD: begin
        acc_d   = mem_rd_data_i;
        state_d = APPLY;
      end
      APPLY: begin
        acc_d = alu_y;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = WRITE;
      end
      WRITE: begin
        if (!noop_q) zero_d = (acc_q == '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strobes are registered, so they are decoded from the state being entered.
    rd_en_d    = (state_d == READ);
    wr_en_d    = (state_d == WRITE) && !noop_d;
    done_d     = (state_d == WRITE);
    wr_data_d  = wr_en_d ? acc_d : wr_data_q;
    mem_addr_d = ((state_d != IDLE) && !noop_d) ? addr_d : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= ALU_INC;
      cnt_q      <= '0;
      addr_q     <= '0;
      acc_q      <= '0;
      noop_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      mem_addr_q <= '0;
      done_q     <= 1'b0;
      zero_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      acc_q      <= acc_d;
      noop_q     <= noop_d;
      rd_en_q    <= rd_en_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      mem_addr_q <= mem_addr_d;
      done_q     <= done_d;
      zero_q     <= zero_d;
    end
  end

  assign req_ready_o   = (state_q == IDLE);
  assign mem_rd_en_o   = rd_en_q;
  assign mem_wr_en_o   = wr_en_q;
  assign mem_wr_data_o = wr_data_q;
  assign mem_addr_o    = mem_addr_q;
  assign done_o        = done_q;
  assign zero_o        = zero_q;

endmodule

// File: tb/tb_cell_rmw_seq.sv
// Scoreboard bench for cell_rmw_seq with a behavioural data memory; expected
// write values, latencies and zero flags are hand-computed per vector.
module tb_cell_rmw_seq;
  import definitions::*;

`ifdef BEEF_CELL_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid_i;
  logic        req_ready_o;
  ALU_OP       req_op_i;
  logic [3:0]  req_count_i;
  logic [15:0] req_addr_i;
  logic        mem_rd_en_o;
  logic [15:0] mem_addr_o;
  logic [7:0]  mem_rd_data_i;
  logic        mem_wr_en_o;
  logic [7:0]  mem_wr_data_o;
  logic        done_o;
  logic        zero_o;

  cell_rmw_seq #(.WIDTH(8), .ADDR_W(16), .CNT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_op_i     (req_op_i),
    .req_count_i  (req_count_i),
    .req_addr_i   (req_addr_i),
    .mem_rd_en_o  (mem_rd_en_o),
    .mem_addr_o   (mem_addr_o),
    .mem_rd_data_i(mem_rd_data_i),
    .mem_wr_en_o  (mem_wr_en_o),
    .mem_wr_data_o(mem_wr_data_o),
    .done_o       (done_o),
    .zero_o       (zero_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (mem_rd_en_o) mem_rd_data_i <= mem[mem_addr_o];
    if (mem_wr_en_o) mem[mem_addr_o] <= mem_wr_data_o;
  end

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        noop;
    logic        zero;
    int          lat;
    int          reads;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rd_cnt   = 0;
  logic zchk_pend = 1'b0;
  logic zchk_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on every done_o.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      rd_cnt    = 0;
      zchk_pend = 1'b0;
    end else begin
      if (zchk_pend) begin
        check("zero_o after write", zero_o, zchk_val);
        zchk_pend = 1'b0;
      end
      if (mem_rd_en_o) begin
        rd_cnt++;
        if (sb.size() != 0) check("read addr", mem_addr_o, sb[0].addr);
      end
      if (mem_wr_en_o && !done_o) check("write without done", mem_wr_en_o, 1'b0);
      if (done_o) begin
        if (sb.size() == 0) begin
          check("spurious done_o", done_o, 1'b0);
        end else begin
          e = sb.pop_front();
          check("latency", cyc - e.acc_cyc, e.lat);
          check("write strobe", mem_wr_en_o, !e.noop);
          check("read count", rd_cnt, e.reads);
          if (!e.noop) begin
            check("write data", mem_wr_data_o, e.data);
            check("write addr", mem_addr_o, e.addr);
          end
          rd_cnt    = 0;
          zchk_pend = 1'b1;
          zchk_val  = e.zero;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  // Issue one request and wait for it to retire; hit marks an expected tag hit.
  task automatic run(input ALU_OP op, input int cnt, input logic [15:0] addr,
                     input logic [7:0] data, input logic z, input bit hit);
    exp_t e;
    int   t;
    t = 0;
    while (!req_ready_o && t < 50) begin
      step();
      t++;
    end
    if (!req_ready_o) check("ready timeout", req_ready_o, 1'b1);
    e.addr = addr;
    e.data = data;
    e.noop = (cnt == 0);
    e.zero = z;
    if (cnt == 0) begin
      e.lat = 1;  e.reads = 0;
    end else if (CACHE && hit) begin
      e.lat = cnt + 1;  e.reads = 0;
    end else begin
      e.lat = cnt + 3;  e.reads = 1;
    end
    e.acc_cyc = cyc;
    sb.push_back(e);
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_count_i = 4'(cnt);
    req_addr_i  = addr;
    step();
    req_valid_i = 1'b0;
    req_addr_i  = 16'hFFFF;
    req_count_i = 4'd9;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      step();
      t++;
    end
    if (sb.size() != 0) begin
      check("retire timeout", sb.size(), 0);
      sb.delete();
    end
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_ready_o"}, req_ready_o, 1'b1);
    check({tag, " mem_rd_en_o"}, mem_rd_en_o, 1'b0);
    check({tag, " mem_wr_en_o"}, mem_wr_en_o, 1'b0);
    check({tag, " mem_addr_o"}, mem_addr_o, 16'h0000);
    check({tag, " mem_wr_data_o"}, mem_wr_data_o, 8'h00);
    check({tag, " done_o"}, done_o, 1'b0);
    check({tag, " zero_o"}, zero_o, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0010] = 8'h05;
    mem[16'h0000] = 8'h02;
    mem[16'h0030] = 8'hFE;
    mem[16'h0050] = 8'h03;
    mem[16'h0040] = 8'h40;
    mem[16'h0020] = 8'h07;
    reset       = 1'b1;
    req_valid_i = 1'b0;
    req_op_i    = ALU_INC;
    req_count_i = 4'd0;
    req_addr_i  = 16'h0000;
    repeat (3) step();
    check_reset_outputs("reset");
    reset = 1'b0;
    step();

    run(ALU_INC, 3,  16'h0010, 8'h08, 1'b0, 1'b0);   // 5+3
    run(ALU_DEC, 2,  16'h0000, 8'h00, 1'b1, 1'b0);   // 2-2
    run(ALU_INC, 0,  16'h0000, 8'h00, 1'b1, 1'b0);   // no-op keeps zero_o
    run(ALU_DEC, 1,  16'h0000, 8'hFF, 1'b0, 1'b1);   // 0-1 wraps
    run(ALU_INC, 15, 16'h0030, 8'h0D, 1'b0, 1'b0);   // FE+15
    run(ALU_DEC, 7,  16'h0050, 8'hFC, 1'b0, 1'b0);   // 3-7
    check("mem[0x10]", mem[16'h0010], 8'h08);
    check("mem[0x00]", mem[16'h0000], 8'hFF);

    // Reset during APPLY of INC 10 on 0x40: no write may follow.
    req_valid_i = 1'b1;
    req_op_i    = ALU_INC;
    req_count_i = 4'd10;
    req_addr_i  = 16'h0040;
    step();
    req_valid_i = 1'b0;
    repeat (5) step();
    check("in-flight ready", req_ready_o, 1'b0);
    reset = 1'b1;
    step();
    check_reset_outputs("mid-run reset");
    reset = 1'b0;
    repeat (15) step();
    check("mem[0x40] untouched", mem[16'h0040], 8'h40);

    // Tag must be invalid after reset, so this reads memory.
    run(ALU_INC, 1,  16'h0050, 8'hFD, 1'b0, 1'b0);
    run(ALU_INC, 1,  16'h0020, 8'h08, 1'b0, 1'b0);
    run(ALU_INC, 2,  16'h0020, 8'h0A, 1'b0, 1'b1);
    run(ALU_INC, 1,  16'h0021, 8'h01, 1'b0, 1'b0);
    check("mem[0x20]", mem[16'h0020], 8'h0A);
    check("mem[0x21]", mem[16'h0021], 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
